// File: rtl/md_sched.sv
// Multiply/divide scheduler for the E stage: runs mult/div as fixed-latency background
// jobs, owns HI/LO, and raises a D-stage stall while a job is in flight.
module md_sched #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int CNT_W    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  md_op_E,
   input  logic        valid_E,
   input  logic [31:0] rs_E,
   input  logic [31:0] rt_E,
   input  logic        md_use_D,
   output logic        start,
   output logic        busy,
   output logic        stall_md,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_rd_E
);

   // state | meaning
   // IDLE  | no job in flight; MT writes and new jobs accepted
   // RUN   | job counting down; pend_* committed when cnt reaches 0
   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       pend_hi, pend_lo;
   logic              pend_wr;

   logic              is_mul, is_div, div_zero;
   logic [31:0]       res_hi, res_lo;
   logic signed [63:0] prod_s;
   logic [63:0]       prod_u;
   logic [31:0]       divisor;
   logic signed [31:0] quo_s, rem_s;
   logic [31:0]       quo_u, rem_u;

   assign is_mul   = (md_op_E == OP_MULT) || (md_op_E == OP_MULTU);
   assign is_div   = (md_op_E == OP_DIV)  || (md_op_E == OP_DIVU);
   assign div_zero = is_div && (rt_E == 32'd0);

   // Divisor forced non-zero so the divider never sees x/0; the result is dropped anyway.
   assign divisor = (rt_E == 32'd0) ? 32'd1 : rt_E;
   assign prod_s  = $signed({{32{rs_E[31]}}, rs_E}) * $signed({{32{rt_E[31]}}, rt_E});
   assign prod_u  = {32'd0, rs_E} * {32'd0, rt_E};
   assign quo_s   = $signed(rs_E) / $signed(divisor);
   assign rem_s   = $signed(rs_E) % $signed(divisor);
   assign quo_u   = rs_E / divisor;
   assign rem_u   = rs_E % divisor;

   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      case (md_op_E)
         OP_MULT:  begin res_hi = prod_s[63:32];  res_lo = prod_s[31:0];  end
         OP_MULTU: begin res_hi = prod_u[63:32];  res_lo = prod_u[31:0];  end
         OP_DIV:   begin res_hi = rem_s;          res_lo = quo_s;         end
         OP_DIVU:  begin res_hi = rem_u;          res_lo = quo_u;         end
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (cnt_q == '0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q == S_RUN);
      start    = valid_E && (is_mul || is_div) && !busy;
      stall_md = md_use_D && (busy || start);
      md_rd_E  = 32'd0;
      if (md_op_E == OP_MFHI)      md_rd_E = hi;
      else if (md_op_E == OP_MFLO) md_rd_E = lo;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
      end else if (start) begin
         cnt_q   <= is_div ? DIV_CNT : MULT_CNT;
         pend_hi <= res_hi;
         pend_lo <= res_lo;
         pend_wr <= !div_zero;
      end else if (state_q == S_RUN) begin
         if (cnt_q == '0) begin
            if (pend_wr) begin
               hi <= pend_hi;
               lo <= pend_lo;
            end
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
      end else if (valid_E) begin
         if (md_op_E == OP_MTHI) hi <= rs_E;
         if (md_op_E == OP_MTLO) lo <= rs_E;
      end
   end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed scenarios plus random traffic against a
// cycle-numbered reference model of job start/commit times and HI/LO contents.
module tb_md_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  md_op_E;
   logic        valid_E;
   logic [31:0] rs_E, rt_E;
   logic        md_use_D;
   logic        start, busy, stall_md;
   logic [31:0] hi, lo, md_rd_E;

   md_sched #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .md_op_E(md_op_E), .valid_E(valid_E),
      .rs_E(rs_E), .rt_E(rt_E), .md_use_D(md_use_D), .start(start),
      .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo), .md_rd_E(md_rd_E)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model: absolute cycle numbers
   int          cyc;
   bit          m_job;
   int          m_end;
   bit          m_wr;
   logic [31:0] m_hi, m_lo, m_phi, m_plo;

   logic        obs_busy, obs_stall;
   logic [31:0] obs_rd;
   int          n_busy, n_stall;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_job = 0; m_end = 0; m_wr = 0;
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0;
   endtask

   task automatic model_edge(input logic [3:0] op, input logic v,
                             input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, sp;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ua = {32'd0, a};           ub = {32'd0, b};
      if (m_job) begin
         if (cyc == m_end) begin
            if (m_wr) begin m_hi = m_phi; m_lo = m_plo; end
            m_job = 0;
         end
      end else if (v) begin
         case (op)
            4'd1: begin sp = sa * sb; m_phi = sp[63:32]; m_plo = sp[31:0];
                        m_job = 1; m_end = cyc + 5; m_wr = 1; end
            4'd2: begin up = ua * ub; m_phi = up[63:32]; m_plo = up[31:0];
                        m_job = 1; m_end = cyc + 5; m_wr = 1; end
            4'd3: begin m_job = 1; m_end = cyc + 10; m_wr = (b != 0);
                        if (b != 0) begin
                           sp = sa % sb; m_phi = sp[31:0];
                           sp = sa / sb; m_plo = sp[31:0];
                        end end
            4'd4: begin m_job = 1; m_end = cyc + 10; m_wr = (b != 0);
                        if (b != 0) begin
                           up = ua % ub; m_phi = up[31:0];
                           up = ua / ub; m_plo = up[31:0];
                        end end
            4'd7: m_hi = a;
            4'd8: m_lo = a;
            default: ;
         endcase
      end
      cyc++;
   endtask

   task automatic step(input logic [3:0] op, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic ud);
      logic m_start;
      logic [31:0] m_rd;
      @(negedge clk);
      md_op_E = op; valid_E = v; rs_E = a; rt_E = b; md_use_D = ud;
      #1;
      m_start = v && (op >= 4'd1) && (op <= 4'd4) && !m_job;
      m_rd = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
      chk("start", {31'd0, start}, {31'd0, m_start});
      chk("busy", {31'd0, busy}, {31'd0, m_job});
      chk("stall_md", {31'd0, stall_md}, {31'd0, ud && (m_job || m_start)});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("md_rd_E", md_rd_E, m_rd);
      obs_busy = busy; obs_stall = stall_md; obs_rd = md_rd_E;
      @(posedge clk);
      model_edge(op, v, a, b);
   endtask

   // launch a job then idle until busy falls; counts busy and stall cycles
   task automatic run_job(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic ud);
      n_busy = 0; n_stall = 0;
      step(op, 1'b1, a, b, ud);
      if (obs_stall) n_stall++;
      for (int i = 0; i < 40; i++) begin
         step(4'd0, 1'b0, 32'd0, 32'd0, ud);
         if (obs_stall) n_stall++;
         if (!obs_busy) break;
         n_busy++;
         if (i == 39) chk("busy_timeout", 32'd1, 32'd0);
      end
   endtask

   initial begin
      reset = 1'b0; md_op_E = 0; valid_E = 0; rs_E = 0; rt_E = 0; md_use_D = 0;
      cyc = 0;
      model_reset();
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      #11 reset = 1'b1;

      run_job(4'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
      chk("mult_busy_len", n_busy, 5);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFEB);

      run_job(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
      chk("multu_busy_len", n_busy, 5);
      chk("multu_hi", hi, 32'h0000_0001);
      chk("multu_lo", lo, 32'hFFFF_FFFE);

      run_job(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
      chk("div_stall_len", n_stall, 11);
      chk("div_busy_len", n_busy, 10);
      step(4'd6, 1'b1, 32'd0, 32'd0, 1'b0);
      chk("div_mflo", obs_rd, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);

      step(4'd7, 1'b1, 32'h11, 32'd0, 1'b0);
      step(4'd8, 1'b1, 32'h22, 32'd0, 1'b0);
      run_job(4'd4, 32'd1234, 32'd0, 1'b0);
      chk("divz_busy_len", n_busy, 10);
      chk("divz_hi", hi, 32'h11);
      chk("divz_lo", lo, 32'h22);

      // illegal ops while busy, then a bubbled MULT while idle
      step(4'd1, 1'b1, 32'd3, 32'd4, 1'b0);
      step(4'd7, 1'b1, 32'hABCD, 32'd0, 1'b1);
      step(4'd1, 1'b1, 32'd9, 32'd9, 1'b1);
      for (int i = 0; i < 5; i++) step(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("ill_hi", hi, 32'd0);
      chk("ill_lo", lo, 32'd12);
      step(4'd1, 1'b0, 32'd5, 32'd5, 1'b1);
      chk("bubble_start", {31'd0, obs_busy}, 32'd0);
      step(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("bubble_busy", {31'd0, obs_busy}, 32'd0);

      // reset in the second busy cycle of a job
      step(4'd1, 1'b1, 32'd3, 32'd4, 1'b0);
      step(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      md_op_E = 0; valid_E = 0;
      #2 reset = 1'b0;
      #1;
      model_reset();
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_hi", hi, 32'd0);
      chk("midrst_lo", lo, 32'd0);
      @(posedge clk);
      cyc++;
      #2 reset = 1'b1;
      for (int i = 0; i < 8; i++) step(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("midrst_nocommit", lo, 32'd0);

      for (int i = 0; i < 600; i++) begin
         logic [3:0]  op;
         logic [31:0] a, b;
         op = 4'($urandom_range(0, 15));
         a  = ($urandom_range(0, 3) == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
         if ($urandom_range(0, 7) == 0) b = 32'd0;
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
         step(op, 1'($urandom_range(0, 3) != 0), a, b, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multiply/divide scheduler for the E stage of the 5-stage pipeline.
- Accepts mult/div/mfhi/mflo/mthi/mtlo operations from E and runs mult/div as fixed-latency background jobs.
- Owns the HI/LO registers.
- Generates a D-stage stall request that the hazard unit ORs into its existing stall (IFU_en/D_REG_en low, E_REG_clr high).

Parameters:
- MULT_LAT, 5, busy cycles for MULT/MULTU (>=1).
- DIV_LAT, 10, busy cycles for DIV/DIVU (>=1).
- CNT_W, 4, counter width; must hold max(MULT_LAT,DIV_LAT)-1.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- md_op_E  in  4  E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE.
- valid_E  in  1  E holds a real instruction (0 = bubble from E_REG_clr).
- rs_E  in  32  operand A (dividend / MT source).
- rt_E  in  32  operand B (divisor).
- md_use_D  in  1  D-stage instruction is any md-type op (1-8).
- start  out  1  combinational: valid_E & op in {1..4} & !busy.
- busy  out  1  registered: job in progress.
- stall_md  out  1  combinational: md_use_D & (busy | start).
- hi  out  32  committed HI.
- lo  out  32  committed LO.
- md_rd_E  out  32  combinational: hi if MFHI, lo if MFLO, else 0; goes to E-level forwarding mux.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low.
- Reset (reset==0, any time, including mid-job):
  - state=IDLE, busy=0, cnt=0, hi=0, lo=0, pending result discarded.
  - Outputs valid immediately, without waiting for a clock edge.
- States: IDLE, RUN.
- IDLE:
  - start=1 at edge t: latch result into pend_hi/pend_lo, load cnt=LAT-1 (LAT per op), go to RUN.
  - busy=1 in cycles t+1 .. t+LAT.
- RUN:
  - cnt!=0: cnt decrements each edge.
  - cnt==0: at that edge commit pend_hi/pend_lo to hi/lo, busy->0, go to IDLE.
  - The committed result is readable in cycle t+LAT+1.
- Arithmetic:
  - MULT: {HI,LO} = signed(rs) * signed(rt), 64-bit.
  - MULTU: unsigned 64-bit product.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - Operands are captured at start; later rs_E/rt_E changes have no effect.
- Divide by zero:
  - Full DIV_LAT busy period still runs (deterministic timing).
  - HI/LO are NOT written at commit.
- MTHI/MTLO:
  - When valid_E & !busy, write rs_E to hi/lo at the next edge.
  - While busy: ignored (illegal; the stall prevents it).
- MFHI/MFLO: md_rd_E always shows the committed value. During busy it shows the old value, which stall_md keeps from being consumed.
- Mult/div arriving in E while busy: start=0, op ignored, state unchanged.
- Bubbles: valid_E=0 causes no writes and no start, regardless of md_op_E.
- Stall:
  - Asserted whenever an md op sits in D while a job is running or starting this cycle.
  - Deasserts in the cycle after the commit edge, so a dependent mfhi enters E in cycle t+LAT+1 and reads the new value.
- LAT=1: busy is high for exactly one cycle; commit occurs at the edge ending that cycle.
- No overlap: at most one job in flight. pend_* are held until commit.

Test Plan:
- Reset mid-job:
  - Stimulus: MULT 3*4, drop reset in the 2nd busy cycle.
  - Required: busy=0, hi=lo=0 immediately; no commit afterwards.
- MULT signed:
  - Stimulus: MULT rs=0xFFFFFFFD (-3), rt=7.
  - Required: busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU:
  - Stimulus: MULTU 0xFFFFFFFF*2.
  - Required: hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- DIV signed with back-to-back MFLO in D:
  - Stimulus: DIV -7/2, MFLO in D.
  - Required: stall_md=1 for 11 cycles (start cycle + 10 busy); MFLO then reads md_rd_E=0xFFFFFFFD; hi=0xFFFFFFFF.
- DIVU by zero:
  - Stimulus: preset hi=0x11, lo=0x22 via MTHI/MTLO, then DIVU x/0.
  - Required: busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- Illegal ops while busy:
  - Stimulus: MTHI 0xABCD and a second MULT presented with valid_E=1 during busy; also MULT with valid_E=0 while idle.
  - Required: all ignored; only the first job's result is committed; bubble causes no start.
